// File: rtl/ntt_seq_pkg.sv
// Shared definitions for the NTT stage sequencer: mode encodings, FSM states,
// and the elaboration-time helpers used to size and count stages.
`timescale 1ns/1ps
package ntt_seq_pkg;

  localparam logic [2:0] CONF_IDLE  = 3'd0;
  localparam logic [2:0] CONF_R2    = 3'd1;
  localparam logic [2:0] CONF_R4    = 3'd2;
  localparam logic [2:0] CONF_MIXED = 3'd3;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Mixed mode runs radix-4 stages first and finishes with one radix-2 stage when LOGN is odd.
  function automatic int stage_count(input logic [2:0] conf, input int logn);
    case (conf)
      CONF_IDLE:  return 0;
      CONF_R2:    return logn;
      CONF_R4:    return logn / 2;
      CONF_MIXED: return (logn / 2) + (logn % 2);
      default:    return 0;
    endcase
  endfunction

endpackage

// File: rtl/ntt_stage_seq_delay.sv
// Fixed-latency register delay line with asynchronous clear; carries the
// read strobe/address forward to become the butterfly write-back strobe/address.
`timescale 1ns/1ps
module ntt_delay_line #(
  parameter int WIDTH = 1,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] dly_q [LAT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LAT; i++) dly_q[i] <= '0;
    end else begin
      dly_q[0] <= din;
      for (int i = 1; i < LAT; i++) dly_q[i] <= dly_q[i-1];
    end
  end

  assign dout = dly_q[LAT-1];

endmodule

// File: rtl/ntt_stage_seq.sv
// NTT stage sequencer: walks DEPTH bank addresses per stage for R2/R4/MIXED
// transforms, then drains the butterfly pipeline. Optional macro STAGE_SEQ_PERF_EN.
`timescale 1ns/1ps
module ntt_stage_seq
  import ntt_seq_pkg::*;
#(
  parameter  int LOGN   = 8,
  parameter  int NBANK  = 4,
  parameter  int BF_LAT = 6,
  localparam int ADDR_W = LOGN - clog2(NBANK),
  localparam int SIDX_W = clog2(LOGN + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        conf,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] tw_idx,
  output logic [SIDX_W-1:0] stage_idx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        done_flag,
  output logic              err,
  output logic [31:0]       perf_cycles
);

  localparam int LAT_W = clog2(BF_LAT + 1);

  state_e            state_q, state_d;
  logic [2:0]        conf_q, conf_d;
  logic [SIDX_W-1:0] s_q, s_d, stg_q, stg_d, k_q, k_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, tw_mask;
  logic [LAT_W-1:0]  drn_q, drn_d;
  logic              err_q, err_d;
  logic              legal, accept, last_drn, final_stg, radix4;
  logic [ADDR_W:0]   wr_bus;

  assign legal     = (conf == CONF_R2) || (conf == CONF_MIXED) ||
                     ((conf == CONF_R4) && ((LOGN % 2) == 0));
  assign accept    = (state_q == ST_IDLE) && start && legal;
  assign last_drn  = (state_q == ST_DRAIN) && (drn_q == LAT_W'(BF_LAT - 1));
  assign final_stg = (stg_q == s_q - SIDX_W'(1));
  assign radix4    = (conf_q == CONF_R4) ||
                     ((conf_q == CONF_MIXED) && (stg_q < SIDX_W'(LOGN / 2)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      conf_q  <= CONF_IDLE;
      s_q     <= '0;
      stg_q   <= '0;
      k_q     <= '0;
      cnt_q   <= '0;
      drn_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      conf_q  <= conf_d;
      s_q     <= s_d;
      stg_q   <= stg_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      drn_q   <= drn_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    conf_d  = conf_q;
    s_d     = s_q;
    stg_d   = stg_q;
    k_d     = k_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          conf_d  = conf;
          s_d     = SIDX_W'(stage_count(conf, LOGN));
          stg_d   = '0;
          k_d     = '0;
          cnt_d   = '0;
          drn_d   = '0;
          state_d = ST_RUN;
        end else if (start) begin
          err_d = 1'b1;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + ADDR_W'(1);
        if (&cnt_q) begin
          drn_d   = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drn_d = drn_q + LAT_W'(1);
        if (last_drn) begin
          drn_d   = '0;
          k_d     = k_q + (radix4 ? SIDX_W'(2) : SIDX_W'(1));
          stg_d   = stg_q + SIDX_W'(1);
          state_d = final_stg ? ST_IDLE : ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Twiddle mask keeps the low min(k, ADDR_W) address bits.
  always_comb begin
    for (int i = 0; i < ADDR_W; i++) tw_mask[i] = (SIDX_W'(i) < k_q);
  end

  always_comb begin
    busy      = (state_q != ST_IDLE);
    rd_en     = (state_q == ST_RUN);
    rd_addr   = rd_en ? cnt_q : '0;
    tw_idx    = rd_en ? (cnt_q & tw_mask) : '0;
    stage_idx = stg_q;
    done_flag = {last_drn && final_stg, last_drn};
    err       = err_q;
  end

  ntt_delay_line #(
    .WIDTH(ADDR_W + 1),
    .LAT  (BF_LAT)
  ) u_wr_dly (
    .clk (clk),
    .rst (rst),
    .din ({rd_en, rd_addr}),
    .dout(wr_bus)
  );

  assign {wr_en, wr_addr} = wr_bus;

`ifdef STAGE_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                    perf_d = '0;
    else if (busy && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_ntt_stage_seq.sv
// Directed bench for ntt_stage_seq: a LOGN=8 and a LOGN=7 instance driven from a
// vector table, plus mid-run start/conf changes, async reset abort and perf count.
`timescale 1ns/1ps
module tb_ntt_stage_seq;
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst;
  logic start8, start7;
  logic [2:0] conf8, conf7;

  logic       busy8, rd_en8, wr_en8, err8;
  logic [5:0] rd_addr8, tw8, wr_addr8;
  logic [3:0] stg8;
  logic [1:0] done8;
  logic [31:0] perf8;

  logic       busy7, rd_en7, wr_en7, err7;
  logic [4:0] rd_addr7, tw7, wr_addr7;
  logic [2:0] stg7;
  logic [1:0] done7;
  logic [31:0] perf7;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ntt_stage_seq #(.LOGN(8), .NBANK(4), .BF_LAT(LAT)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .conf(conf8), .busy(busy8),
    .rd_en(rd_en8), .rd_addr(rd_addr8), .tw_idx(tw8), .stage_idx(stg8),
    .wr_en(wr_en8), .wr_addr(wr_addr8), .done_flag(done8), .err(err8),
    .perf_cycles(perf8));

  ntt_stage_seq #(.LOGN(7), .NBANK(4), .BF_LAT(LAT)) dut7 (
    .clk(clk), .rst(rst), .start(start7), .conf(conf7), .busy(busy7),
    .rd_en(rd_en7), .rd_addr(rd_addr7), .tw_idx(tw7), .stage_idx(stg7),
    .wr_en(wr_en7), .wr_addr(wr_addr7), .done_flag(done7), .err(err7),
    .perf_cycles(perf7));

  typedef struct {
    bit         is7;
    logic [2:0] cf;
    int         exp_s;
    bit         exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seq(input int vi, input bit is7, input logic [2:0] cf,
                         input int exp_s, input bit exp_err, input int poke);
    int depth, aw, total, window, c, idx, k, mask;
    int n_d0, first_d0, d1_cyc, busy_cnt, busy_low, n_err, n_rd;
    int rd_in_stg, stg, bad_rd, bad_tw, bad_wr;
    int h_en[LAT], h_a[LAT];
    int re, ra, tw, we, wa, d0, d1, bz, er;
    string tag;
    depth = is7 ? 32 : 64;
    aw    = is7 ? 5 : 6;
    total = exp_s * (depth + LAT);
    window = exp_err ? 10 : total + 8;
    n_d0 = 0; first_d0 = -1; d1_cyc = -1; busy_cnt = 0; busy_low = -1;
    n_err = 0; n_rd = 0; rd_in_stg = 0; stg = 0; bad_rd = 0; bad_tw = 0; bad_wr = 0;
    for (int i = 0; i < LAT; i++) begin h_en[i] = 0; h_a[i] = 0; end
    tag = $sformatf("v%0d", vi);
    if (is7) begin conf7 = cf; start7 = 1'b1; end
    else     begin conf8 = cf; start8 = 1'b1; end
    tick();
    start7 = 1'b0; start8 = 1'b0;
    for (c = 1; c <= window; c++) begin
      if (c == poke)     begin start8 = 1'b1; conf8 = 3'd3; end
      if (c == poke + 1) start8 = 1'b0;
      if (is7) begin
        re = int'(rd_en7); ra = int'(rd_addr7); tw = int'(tw7); we = int'(wr_en7);
        wa = int'(wr_addr7); d0 = int'(done7[0]); d1 = int'(done7[1]);
        bz = int'(busy7); er = int'(err7);
      end else begin
        re = int'(rd_en8); ra = int'(rd_addr8); tw = int'(tw8); we = int'(wr_en8);
        wa = int'(wr_addr8); d0 = int'(done8[0]); d1 = int'(done8[1]);
        bz = int'(busy8); er = int'(err8);
      end
      if (bz != 0) busy_cnt++;
      else if (busy_low < 0 && busy_cnt > 0) busy_low = c;
      if (er != 0) n_err++;
      idx = c % LAT;
      if (we != h_en[idx] || (we != 0 && wa != h_a[idx])) bad_wr++;
      h_en[idx] = re; h_a[idx] = ra;
      if (re != 0) begin
        k = (cf == 3'd1) ? stg : 2 * stg;
        mask = (1 << ((k < aw) ? k : aw)) - 1;
        if (ra != rd_in_stg) bad_rd++;
        if (tw != (rd_in_stg & mask)) bad_tw++;
        rd_in_stg++;
        n_rd++;
      end
      if (d0 != 0) begin
        n_d0++;
        stg++;
        rd_in_stg = 0;
        if (first_d0 < 0) first_d0 = c;
      end
      if (d1 != 0 && d1_cyc < 0) d1_cyc = c;
      tick();
    end
    if (exp_err) begin
      check({tag, "_err_pulses"}, n_err, 1);
      check({tag, "_busy_cycles"}, busy_cnt, 0);
    end else begin
      check({tag, "_err_pulses"}, n_err, 0);
      check({tag, "_done0_count"}, n_d0, exp_s);
      check({tag, "_first_done0"}, first_d0, depth + LAT);
      check({tag, "_done1_cycle"}, d1_cyc, total);
      check({tag, "_busy_cycles"}, busy_cnt, total);
      check({tag, "_busy_low_cycle"}, busy_low, total + 1);
      check({tag, "_reads"}, n_rd, exp_s * depth);
      check({tag, "_rd_addr_bad"}, bad_rd, 0);
      check({tag, "_tw_idx_bad"}, bad_tw, 0);
      check({tag, "_wr_delay_bad"}, bad_wr, 0);
    end
    repeat (3) tick();
  endtask

  initial begin
    int bad;
    int exp_perf;
    vecs[0] = '{is7: 1'b0, cf: 3'd1, exp_s: 8, exp_err: 1'b0};
    vecs[1] = '{is7: 1'b0, cf: 3'd2, exp_s: 4, exp_err: 1'b0};
    vecs[2] = '{is7: 1'b0, cf: 3'd3, exp_s: 4, exp_err: 1'b0};
    vecs[3] = '{is7: 1'b1, cf: 3'd3, exp_s: 4, exp_err: 1'b0};
    vecs[4] = '{is7: 1'b1, cf: 3'd1, exp_s: 7, exp_err: 1'b0};
    vecs[5] = '{is7: 1'b1, cf: 3'd2, exp_s: 0, exp_err: 1'b1};
    vecs[6] = '{is7: 1'b0, cf: 3'd0, exp_s: 0, exp_err: 1'b1};
    vecs[7] = '{is7: 1'b0, cf: 3'd5, exp_s: 0, exp_err: 1'b1};

    rst = 1'b1; start8 = 1'b0; start7 = 1'b0; conf8 = 3'd0; conf7 = 3'd0;
    repeat (3) tick();
    check("reset_busy8", int'(busy8), 0);
    check("reset_rd_en8", int'(rd_en8), 0);
    check("reset_wr_en8", int'(wr_en8), 0);
    check("reset_done8", int'(done8), 0);
    check("reset_err8", int'(err8), 0);
    check("reset_perf8", int'(perf8), 0);
    check("reset_busy7", int'(busy7), 0);
    rst = 1'b0;
    repeat (2) tick();

    for (int v = 0; v < 8; v++)
      run_seq(v, vecs[v].is7, vecs[v].cf, vecs[v].exp_s, vecs[v].exp_err, -1);

    // start re-pulsed with conf=MIXED at cycle 30 of an R2 run
    run_seq(8, 1'b0, 3'd1, 8, 1'b0, 30);

    // async reset at cycle 100 of an R2 run
    conf8 = 3'd1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (99) tick();
    check("pre_rst_stage_idx", int'(stg8), 1);
    check("pre_rst_rd_addr", int'(rd_addr8), 29);
    rst = 1'b1;
    #1;
    check("rst_busy", int'(busy8), 0);
    check("rst_rd_en", int'(rd_en8), 0);
    check("rst_rd_addr", int'(rd_addr8), 0);
    check("rst_stage_idx", int'(stg8), 0);
    check("rst_wr_en", int'(wr_en8), 0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (done8 != 2'b00 || busy8 != 1'b0 || wr_en8 != 1'b0) bad++;
    end
    check("rst_hold_quiet", bad, 0);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done8 != 2'b00 || busy8 != 1'b0 || wr_en8 != 1'b0) bad++;
    end
    check("post_rst_no_done", bad, 0);

    run_seq(9, 1'b0, 3'd1, 8, 1'b0, -1);
`ifdef STAGE_SEQ_PERF_EN
    exp_perf = 560;
`else
    exp_perf = 0;
`endif
    check("perf_cycles_r2", int'(perf8), exp_perf);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/ntt_stage_seq.md
Name: ntt_stage_seq

Overview:
Parametrised stage sequencer for the mixed-radix NTT datapath. It runs a full transform over N = 2^LOGN coefficients that are spread across NBANK memory banks. Each cycle it reads one word per bank and generates the matching write-back address after the butterfly pipeline latency. Supported sequences are all-radix-2, all-radix-4 and mixed radix-4/radix-2. It replaces the fixed 4-bank controller inside top_stage and reports per-stage and end-of-transform completion on done_flag.

Parameters:
LOGN, 8, log2 of transform length N.
NBANK, 4, number of coefficient banks; power of 2, at least 2.
BF_LAT, 6, butterfly pipeline latency from read to write in cycles; at least 1.
Derived: DEPTH = N/NBANK; ADDR_W = LOGN - log2(NBANK); SIDX_W = clog2(LOGN+1).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
start  in  1  one-cycle start request, sampled only in IDLE
conf  in  3  mode, latched on accepted start: 0 idle, 1 R2, 2 R4, 3 MIXED, 4-7 reserved
busy  out  1  high from the cycle after accepted start until the cycle after final done
rd_en  out  1  bank read strobe, common to all banks
rd_addr  out  ADDR_W  bank read address
tw_idx  out  ADDR_W  twiddle index aligned with rd_addr
stage_idx  out  SIDX_W  current stage number, 0-based
wr_en  out  1  rd_en delayed BF_LAT cycles
wr_addr  out  ADDR_W  rd_addr delayed BF_LAT cycles
done_flag  out  2  bit0 end-of-stage pulse; bit1 end-of-transform pulse
err  out  1  one-cycle pulse when a start is rejected
perf_cycles  out  32  busy-cycle count (see Optional Feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, delay line cleared. Reset mid-operation aborts immediately; no done pulse is issued.
- FSM states: IDLE, RUN, DRAIN.
- IDLE with start=1 and a legal conf: latch conf, compute stage count S, clear stage_idx, counter cnt and consumed-bit count k. Go to RUN next cycle.
- Illegal start (conf 0, conf 4-7, or R4 with odd LOGN): stay in IDLE and pulse err for one cycle.
- start while busy: ignored, no err. conf changes while busy: ignored.
- Stage count S:
  - R2: LOGN stages, each radix-2.
  - R4: LOGN/2 stages, each radix-4.
  - MIXED: floor(LOGN/2) radix-4 stages, then one radix-2 stage if LOGN is odd.
- RUN, per cycle: rd_en=1, rd_addr=cnt, tw_idx = cnt AND ((1<<min(k,ADDR_W))-1), cnt increments.
  - After the cycle with cnt=DEPTH-1: go to DRAIN, cnt wraps to 0.
- DRAIN: rd_en=0 for exactly BF_LAT cycles.
  - The last DRAIN cycle coincides with the stage's last wr_en. done_flag[0] pulses in that cycle.
  - On that cycle, k += 1 (radix-2 stage) or 2 (radix-4 stage), and stage_idx increments.
  - If more stages remain, go to RUN; the next read is in the following cycle, so there is no read/write overlap across stages.
  - If this was the final stage, done_flag[1] pulses together with done_flag[0], and the FSM goes to IDLE; busy drops next cycle.
- Cycle budget per stage: DEPTH+BF_LAT. Total busy cycles = S*(DEPTH+BF_LAT).
- wr_en/wr_addr: exact BF_LAT-cycle delay of rd_en/rd_addr, independent of FSM state.
- Counter widths: cnt is ADDR_W bits and wraps naturally. k is SIDX_W bits and never exceeds LOGN.

Optional Feature:
STAGE_SEQ_PERF_EN
- Defined: perf_cycles is cleared on accepted start, increments every cycle busy=1, and holds after done until the next start. Saturates at 2^32-1.
- Undefined: the perf_cycles port is present and tied to 0; no counter logic.

Decomposition:
Package ntt_seq_pkg holds:
- conf encodings (CONF_IDLE, CONF_R2, CONF_R4, CONF_MIXED);
- FSM state typedef;
- clog2 function;
- stage-count function stage_count(conf, LOGN).

Sub-module ntt_delay_line: parameters WIDTH and LAT, fields clk, rst, din, dout. Used once for the {rd_en, rd_addr} to {wr_en, wr_addr} path.

Test Plan:
- LOGN=8, NBANK=4, BF_LAT=6, conf=1, start at cycle 0 -> rd_en high cycles 1-64 with rd_addr 0..63; wr_en high cycles 7-70; done_flag[0] at cycle 70; 8 done_flag[0] pulses total; done_flag[1] at cycle 560; busy low at 561.
- Same parameters, conf=2 -> 4 stages; tw_idx masks 0, 0x3, 0xF, 0x3F in stages 0-3; done_flag[1] at cycle 280.
- LOGN=7, NBANK=4, conf=3 -> 3 radix-4 stages plus 1 radix-2 stage (DEPTH=32); done_flag[1] at cycle 4*38=152. Same LOGN=7 with conf=2 -> err pulse, busy stays 0.
- conf changed 1->3 and start re-pulsed mid-run -> ignored; sequence completes as R2 with no err.
- rst asserted at cycle 100 of an R2 run -> all outputs 0 asynchronously; no done pulse; a new start after reset runs a clean full sequence.
- With STAGE_SEQ_PERF_EN, after the R2 run perf_cycles=560; without the macro it reads 0.
